// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron datapath: FSM state encoding,
// sign-magnitude widths and the saturation limit.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int SM_PROD_W = 16;
    localparam int SM_DATA_W = 8;
    localparam logic [SM_DATA_W-2:0] SAT_MAG = 7'd127;

    // Packs sign and magnitude, forcing a positive sign on zero so 8'h80 never appears.
    function automatic logic [SM_DATA_W-1:0] sm_pack(input logic neg,
                                                     input logic [SM_DATA_W-2:0] mag);
        return {neg && (mag != '0), mag};
    endfunction

endpackage

// File: rtl/sm2tc.sv
// Combinational sign-magnitude to two's-complement converter, sign-extended
// to OUT_W bits. Negative zero maps to zero.
module sm2tc #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-1:0]  sm,
    output logic [OUT_W-1:0] tc
);

    logic [OUT_W-1:0] mag;

    assign mag = OUT_W'(sm[IN_W-2:0]);
    assign tc  = (sm[IN_W-1] && (mag != '0)) ? (~mag + OUT_W'(1)) : mag;

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: bias + N_INPUTS sign-magnitude products, rescaled by FRAC_SH,
// saturated to 8-bit sign-magnitude. Define NEURON_RELU_EN to clamp negative results to zero.
import nn_pkg::*;

module neuron_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 24,
    parameter int FRAC_SH  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SM_DATA_W-1:0] bias,
    input  logic                 prod_valid,
    input  logic [SM_PROD_W-1:0] prod,
    output logic                 prod_ready,
    output logic                 out_valid,
    output logic [SM_DATA_W-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t               state;
    state_t               state_nxt;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     count;
    logic [ACC_W-1:0]     bias_tc;
    logic [ACC_W-1:0]     prod_tc;
    logic                 accept;
    logic                 last_accept;
    logic                 acc_neg;
    logic [ACC_W-1:0]     acc_mag;
    logic [ACC_W-1:0]     mag_sh;
    logic [SM_DATA_W-2:0] sat_mag;
    logic [SM_DATA_W-1:0] result;

    sm2tc #(.IN_W(SM_DATA_W), .OUT_W(ACC_W)) u_bias_conv (
        .sm (bias),
        .tc (bias_tc)
    );

    sm2tc #(.IN_W(SM_PROD_W), .OUT_W(ACC_W)) u_prod_conv (
        .sm (prod),
        .tc (prod_tc)
    );

    assign prod_ready  = (state == ACCUM);
    assign out_valid   = (state == OUT);
    assign busy        = (state != IDLE);
    assign accept      = prod_valid && prod_ready;
    assign last_accept = accept && (count == CNT_W'(N_INPUTS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = ACCUM;
            ACCUM:   if (last_accept) state_nxt = SCALE;
            SCALE:                    state_nxt = OUT;
            OUT:     if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Magnitude is shifted rather than the signed sum, so rounding is toward zero.
    always_comb begin
        acc_neg = acc[ACC_W-1];
        acc_mag = acc_neg ? (~acc + ACC_W'(1)) : acc;
        mag_sh  = acc_mag >> FRAC_SH;
        sat_mag = (mag_sh > ACC_W'(SAT_MAG)) ? SAT_MAG : mag_sh[SM_DATA_W-2:0];
`ifdef NEURON_RELU_EN
        result  = acc_neg ? '0 : sm_pack(1'b0, sat_mag);
`else
        result  = sm_pack(acc_neg, sat_mag);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (state == IDLE && start) begin
            acc   <= bias_tc << FRAC_SH;
            count <= '0;
        end else if (accept) begin
            acc   <= acc + prod_tc;
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (state == SCALE) begin
            out_data <= result;
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Scoreboard bench for neuron_accumulator: expected results are queued at stimulus
// time and popped by a monitor on each output handshake.
module tb_neuron_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bias;
    logic        prod_valid;
    logic [15:0] prod;
    logic        prod_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;

    int          total;
    int          bad;
    logic [7:0]  exp_q[$];
    logic [15:0] prods[8];

    neuron_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bias       (bias),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Monitor: the handshake completes on the next rising edge, so compare now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", 32'(out_data), 32'hDEAD);
            end else begin
                checkOutput("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic int tcv(input logic [15:0] v, input int w);
        int m;
        m = (w == 8) ? int'(v[6:0]) : int'(v[14:0]);
        return ((w == 8) ? v[7] : v[15]) ? -m : m;
    endfunction

    function automatic logic [7:0] refModel(input logic [7:0] b);
        int  sum;
        int  mag;
        bit  neg;
        sum = tcv({8'h00, b}, 8) * 128;
        for (int i = 0; i < 8; i++) sum += tcv(prods[i], 16);
        neg = (sum < 0);
        mag = (neg ? -sum : sum) / 128;
        if (mag > 127) mag = 127;
`ifdef NEURON_RELU_EN
        if (neg) mag = 0;
`endif
        if (mag == 0) return 8'h00;
        return {neg, 7'(mag)};
    endfunction

    task automatic fillConst(input logic [15:0] v);
        for (int i = 0; i < 8; i++) prods[i] = v;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] want,
                                 input bit gaps, input int hold);
        int accepted;
        int cyc;
        bit took;
        exp_q.push_back(want);
        out_ready = (hold == 0);
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 8 && cyc < 100) begin
            prod_valid = gaps ? (cyc % 3 == 0) : 1'b1;
            prod = prods[accepted];
            @(negedge clk);
            took = prod_valid && prod_ready;
            @(posedge clk); #1;
            if (took) accepted++;
            cyc++;
        end
        prod_valid = 1'b0;
        checkOutput("accept_cnt", 32'(accepted), 32'd8);
        if (gaps) checkOutput("gap_cycles", 32'(cyc), 32'd22);
        @(negedge clk);
        checkOutput("ready_drop", 32'(prod_ready), 32'd0);
        checkOutput("scale_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lat_valid", 32'(out_valid), 32'd1);
        if (hold > 0) begin
            start = 1'b1;
            bias  = 8'h7F;
            repeat (hold) begin
                @(posedge clk); #1;
                @(negedge clk);
                checkOutput("hold_data", 32'(out_data), 32'(want));
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_ready", 32'(prod_ready), 32'd0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = 1'b1;
        end
        cyc = 0;
        while (out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("valid_clear", 32'(out_valid), 32'd0);
        checkOutput("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic applyReset();
        out_ready = 1'b1;
        start = 1'b1;
        bias  = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 16'h1000;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_prod_ready", 32'(prod_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        prod_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        clk = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        bias = 8'h00;
        prod_valid = 1'b0;
        prod = 16'h0000;
        out_ready = 1'b0;
        total = 0;
        bad = 0;
        #1;
        checkOutput("reset_prod_ready", 32'(prod_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        fillConst(16'h1000);
        applyStimulus(8'h00, 8'h7F, 1'b0, 0);

        for (int i = 0; i < 8; i++) prods[i] = (i % 2 == 1) ? 16'h9000 : 16'h1000;
        applyStimulus(8'h05, 8'h05, 1'b0, 0);

        fillConst(16'h8800);
`ifdef NEURON_RELU_EN
        applyStimulus(8'h00, 8'h00, 1'b0, 0);
`else
        applyStimulus(8'h00, 8'hFF, 1'b0, 0);
`endif

        fillConst(16'h8100);
`ifdef NEURON_RELU_EN
        applyStimulus(8'h81, 8'h00, 1'b0, 0);
`else
        applyStimulus(8'h81, 8'h91, 1'b0, 0);
`endif

        fillConst(16'h0100);
        applyStimulus(8'h00, 8'h10, 1'b1, 3);

        applyReset();
        fillConst(16'h0400);
        applyStimulus(8'h00, 8'h40, 1'b0, 0);

        fillConst(16'h8000);
        applyStimulus(8'h80, 8'h00, 1'b0, 0);
        fillConst(16'h8001);
        applyStimulus(8'h00, 8'h00, 1'b0, 0);

        fillConst(16'h80C1);
`ifdef NEURON_RELU_EN
        applyStimulus(8'h00, 8'h00, 1'b0, 0);
`else
        applyStimulus(8'h00, 8'h8C, 1'b0, 0);
`endif

        for (int t = 0; t < 4; t++) begin
            rb = 8'($urandom);
            for (int i = 0; i < 8; i++) prods[i] = 16'($urandom_range(0, 65535));
            applyStimulus(rb, refModel(rb), t[0], 0);
        end

        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
